// File: rtl/pu_or1k_pfpu32_pkg.sv
// Shared constants for the pfpu32 pipes: rounding modes, special encodings and
// bit positions inside the 28-bit working fraction.
package pu_or1k_pfpu32_pkg;

    localparam logic [1:0] RM_NEAREST = 2'b00;
    localparam logic [1:0] RM_ZERO    = 2'b01;
    localparam logic [1:0] RM_PLUSINF = 2'b10;
    localparam logic [1:0] RM_MININF  = 2'b11;

    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] INF  = 32'h7F800000;
    localparam logic [31:0] MAXF = 32'h7F7FFFFF;

    // Working fraction layout: carry, hidden, 23 fraction bits, guard, round, sticky
    localparam int FR_CARRY  = 27;
    localparam int FR_HIDDEN = 26;
    localparam int FR_LSB    = 3;
    localparam int FR_G      = 2;
    localparam int FR_R      = 1;
    localparam int FR_S      = 0;

endpackage

// File: rtl/pu_or1k_pfpu32_rnd_inc.sv
// Round-up decision for a hidden..sticky fraction and the 24-bit mantissa
// incrementer; bit 24 of mant_rnd is the mantissa carry-out.
module pu_or1k_pfpu32_rnd_inc
    import pu_or1k_pfpu32_pkg::*;
(
    input  logic [1:0]  rmode,
    input  logic        sign,
    input  logic [26:0] fract,
    output logic [24:0] mant_rnd,
    output logic        inexact
);

    logic lsb;
    logic g;
    logic rs;
    logic up;

    always_comb begin
        lsb = fract[FR_LSB];
        g   = fract[FR_G];
        rs  = fract[FR_R] | fract[FR_S];
        case (rmode)
            RM_NEAREST: up = g & (rs | lsb);
            RM_PLUSINF: up = ~sign & (g | rs);
            RM_MININF:  up = sign & (g | rs);
            default:    up = 1'b0;
        endcase
        mant_rnd = {1'b0, fract[FR_HIDDEN:FR_LSB]} + {24'd0, up};
        inexact  = g | rs;
    end

endmodule

// File: rtl/pu_or1k_pfpu32_addsub_rndpack.sv
// Tail of the pfpu32 add/sub pipe: final align (stage 1), then round, overflow/
// underflow detection and binary32 packing with FPCSR flags (stage 2).
module pu_or1k_pfpu32_addsub_rndpack
    import pu_or1k_pfpu32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        adv_i,
    input  logic [1:0]  rmode_i,
    input  logic        add_rdy_i,
    input  logic        add_sign_i,
    input  logic        add_sub_0_i,
    input  logic [4:0]  add_shl_i,
    input  logic [9:0]  add_exp10shl_i,
    input  logic [9:0]  add_exp10sh0_i,
    input  logic [27:0] add_fract28_i,
    input  logic        add_inv_i,
    input  logic        add_inf_i,
    input  logic        add_snan_i,
    input  logic        add_qnan_i,
    input  logic        add_anan_sign_i,
    output logic [31:0] result_o,
    output logic        rdy_o,
    output logic        ine_o,
    output logic        ovf_o,
    output logic        unf_o,
    output logic        inf_o,
    output logic        zer_o,
    output logic        ivf_o,
    output logic        snan_o,
    output logic        qnan_o
);

    // Pipe handshake: every stage register (data and ready bit) loads only when
    // adv_i=1 and holds otherwise; flush_i drops both ready bits and wins over adv_i.
    logic        s1_rdy;
    logic [1:0]  s1_rmode;
    logic        s1_sign, s1_sub_0, s1_inv, s1_inf, s1_snan, s1_qnan, s1_anan_sign;
    logic [9:0]  s1_exp;
    logic [26:0] s1_fract;

    logic [26:0] al_fract;
    logic [9:0]  al_exp;

    always_comb begin
        if (add_fract28_i[FR_CARRY]) begin
            al_fract = {add_fract28_i[27:2], add_fract28_i[1] | add_fract28_i[0]};
            al_exp   = add_exp10sh0_i + 10'd1;
        end else begin
            al_fract = add_fract28_i[26:0] << add_shl_i;
            al_exp   = add_exp10shl_i;
        end
        if (al_exp == 10'd1 && !al_fract[FR_HIDDEN]) al_exp = 10'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_rdy       <= 1'b0;
            s1_rmode     <= 2'b00;
            s1_sign      <= 1'b0;
            s1_sub_0     <= 1'b0;
            s1_inv       <= 1'b0;
            s1_inf       <= 1'b0;
            s1_snan      <= 1'b0;
            s1_qnan      <= 1'b0;
            s1_anan_sign <= 1'b0;
            s1_exp       <= 10'd0;
            s1_fract     <= 27'd0;
        end else begin
            if (flush_i)    s1_rdy <= 1'b0;
            else if (adv_i) s1_rdy <= add_rdy_i;
            if (adv_i) begin
                s1_rmode     <= rmode_i;
                s1_sign      <= add_sign_i;
                s1_sub_0     <= add_sub_0_i;
                s1_inv       <= add_inv_i;
                s1_inf       <= add_inf_i;
                s1_snan      <= add_snan_i;
                s1_qnan      <= add_qnan_i;
                s1_anan_sign <= add_anan_sign_i;
                s1_exp       <= al_exp;
                s1_fract     <= al_fract;
            end
        end
    end

    logic [24:0] mant_rnd;
    logic        rnd_ine;

    pu_or1k_pfpu32_rnd_inc u_rnd_inc (
        .rmode    (s1_rmode),
        .sign     (s1_sign),
        .fract    (s1_fract),
        .mant_rnd (mant_rnd),
        .inexact  (rnd_ine)
    );

    logic [9:0]  exp_rnd;
    logic        ovf, to_inf;
    logic [31:0] n_res;
    logic        n_ine, n_ovf, n_unf, n_inf, n_zer, n_ivf, n_snan, n_qnan;

    always_comb begin
        // A denormal that rounds into the hidden bit becomes the smallest normal
        exp_rnd = s1_exp + {9'd0, mant_rnd[24]};
        if (s1_exp == 10'd0 && mant_rnd[23]) exp_rnd = 10'd1;
        ovf    = (exp_rnd >= 10'd255);
        to_inf = (s1_rmode == RM_NEAREST) |
                 ((s1_rmode == RM_PLUSINF) & ~s1_sign) |
                 ((s1_rmode == RM_MININF) & s1_sign);
        n_res  = 32'd0;
        n_ine  = 1'b0;
        n_ovf  = 1'b0;
        n_unf  = 1'b0;
        n_inf  = 1'b0;
        n_zer  = 1'b0;
        n_ivf  = 1'b0;
        n_snan = 1'b0;
        n_qnan = 1'b0;
        if (s1_snan | s1_qnan) begin
            n_res  = {s1_anan_sign, QNAN[30:0]};
            n_snan = s1_snan;
            n_qnan = s1_qnan;
            n_ivf  = s1_snan;
        end else if (s1_inv) begin
            n_res  = QNAN;
            n_ivf  = 1'b1;
            n_qnan = 1'b1;
        end else if (s1_inf) begin
            n_res = {s1_sign, INF[30:0]};
            n_inf = 1'b1;
        end else if (s1_sub_0) begin
            n_res = {(s1_rmode == RM_MININF), 31'd0};
            n_zer = 1'b1;
        end else if (ovf) begin
            n_res = to_inf ? {s1_sign, INF[30:0]} : {s1_sign, MAXF[30:0]};
            n_ovf = 1'b1;
            n_ine = 1'b1;
            n_inf = to_inf;
        end else begin
            n_res = {s1_sign, exp_rnd[7:0], mant_rnd[22:0]};
            n_ine = rnd_ine;
            n_unf = rnd_ine & (exp_rnd == 10'd0);
            n_zer = (exp_rnd == 10'd0) && (mant_rnd[22:0] == 23'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_o    <= 1'b0;
            result_o <= 32'd0;
            ine_o    <= 1'b0;
            ovf_o    <= 1'b0;
            unf_o    <= 1'b0;
            inf_o    <= 1'b0;
            zer_o    <= 1'b0;
            ivf_o    <= 1'b0;
            snan_o   <= 1'b0;
            qnan_o   <= 1'b0;
        end else begin
            if (flush_i)    rdy_o <= 1'b0;
            else if (adv_i) rdy_o <= s1_rdy;
            if (adv_i) begin
                result_o <= n_res;
                ine_o    <= n_ine;
                ovf_o    <= n_ovf;
                unf_o    <= n_unf;
                inf_o    <= n_inf;
                zer_o    <= n_zer;
                ivf_o    <= n_ivf;
                snan_o   <= n_snan;
                qnan_o   <= n_qnan;
            end
        end
    end

endmodule

// File: tb/tb_pu_or1k_pfpu32_addsub_rndpack.sv
// Directed bench for the add/sub round-and-pack tail: arithmetic vectors,
// specials, stalls, flush and mid-pipe reset.
module tb_pu_or1k_pfpu32_addsub_rndpack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i, adv_i;
    logic [1:0]  rmode_i;
    logic        add_rdy_i, add_sign_i, add_sub_0_i;
    logic [4:0]  add_shl_i;
    logic [9:0]  add_exp10shl_i, add_exp10sh0_i;
    logic [27:0] add_fract28_i;
    logic        add_inv_i, add_inf_i, add_snan_i, add_qnan_i, add_anan_sign_i;
    logic [31:0] result_o;
    logic        rdy_o, ine_o, ovf_o, unf_o, inf_o, zer_o, ivf_o, snan_o, qnan_o;

    int vectors = 0;
    int miscompares = 0;

    // Flag vector order: {ine, ovf, unf, inf, zer, ivf, snan, qnan}
    localparam logic [7:0] F_INE  = 8'h80;
    localparam logic [7:0] F_OVF  = 8'h40;
    localparam logic [7:0] F_UNF  = 8'h20;
    localparam logic [7:0] F_INF  = 8'h10;
    localparam logic [7:0] F_ZER  = 8'h08;
    localparam logic [7:0] F_IVF  = 8'h04;
    localparam logic [7:0] F_SNAN = 8'h02;
    localparam logic [7:0] F_QNAN = 8'h01;

    pu_or1k_pfpu32_addsub_rndpack dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_i         (flush_i),
        .adv_i           (adv_i),
        .rmode_i         (rmode_i),
        .add_rdy_i       (add_rdy_i),
        .add_sign_i      (add_sign_i),
        .add_sub_0_i     (add_sub_0_i),
        .add_shl_i       (add_shl_i),
        .add_exp10shl_i  (add_exp10shl_i),
        .add_exp10sh0_i  (add_exp10sh0_i),
        .add_fract28_i   (add_fract28_i),
        .add_inv_i       (add_inv_i),
        .add_inf_i       (add_inf_i),
        .add_snan_i      (add_snan_i),
        .add_qnan_i      (add_qnan_i),
        .add_anan_sign_i (add_anan_sign_i),
        .result_o        (result_o),
        .rdy_o           (rdy_o),
        .ine_o           (ine_o),
        .ovf_o           (ovf_o),
        .unf_o           (unf_o),
        .inf_o           (inf_o),
        .zer_o           (zer_o),
        .ivf_o           (ivf_o),
        .snan_o          (snan_o),
        .qnan_o          (qnan_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input logic adv);
        adv_i = adv;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] rm, input logic sign, input logic [4:0] shl,
                         input logic [9:0] e_shl, input logic [9:0] e_sh0, input logic [27:0] fr);
        add_rdy_i       = 1'b1;
        rmode_i         = rm;
        add_sign_i      = sign;
        add_shl_i       = shl;
        add_exp10shl_i  = e_shl;
        add_exp10sh0_i  = e_sh0;
        add_fract28_i   = fr;
        add_sub_0_i     = 1'b0;
        add_inv_i       = 1'b0;
        add_inf_i       = 1'b0;
        add_snan_i      = 1'b0;
        add_qnan_i      = 1'b0;
        add_anan_sign_i = 1'b0;
    endtask

    task automatic check_rdy(input string tag, input logic exp_rdy);
        vectors++;
        assert (rdy_o === exp_rdy) else begin
            miscompares++;
            $error("FAIL %s rdy: observed %b expected %b", tag, rdy_o, exp_rdy);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] exp_res,
                         input logic [7:0] exp_flg, input logic exp_rdy);
        logic [7:0] flg;
        flg = {ine_o, ovf_o, unf_o, inf_o, zer_o, ivf_o, snan_o, qnan_o};
        check_rdy(tag, exp_rdy);
        vectors++;
        assert (result_o === exp_res) else begin
            miscompares++;
            $error("FAIL %s result: observed %h expected %h", tag, result_o, exp_res);
        end
        vectors++;
        assert (flg === exp_flg) else begin
            miscompares++;
            $error("FAIL %s flags: observed %b expected %b", tag, flg, exp_flg);
        end
    endtask

    // Op already driven: first advance must not yet show rdy_o, second must
    task automatic run_op(input string tag, input logic [31:0] exp_res, input logic [7:0] exp_flg);
        tick(1'b1);
        check_rdy({tag, "_lat1"}, 1'b0);
        add_rdy_i = 1'b0;
        tick(1'b1);
        check(tag, exp_res, exp_flg, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        flush_i = 1'b0;
        adv_i = 1'b0;
        drive(2'b00, 1'b0, 5'd0, 10'd0, 10'd0, 28'd0);
        add_rdy_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 32'h0, 8'h00, 1'b0);
        rst_n = 1'b1;
        tick(1'b0);

        drive(2'b00, 1'b0, 5'd0, 10'd0, 10'd127, 28'h8000000);
        run_op("one_plus_one", 32'h40000000, 8'h00);
        drive(2'b00, 1'b0, 5'd0, 10'd127, 10'd127, 28'h400000C);
        run_op("tie_rne", 32'h3F800002, F_INE);
        drive(2'b01, 1'b0, 5'd0, 10'd127, 10'd127, 28'h400000C);
        run_op("tie_rtz", 32'h3F800001, F_INE);
        drive(2'b00, 1'b0, 5'd0, 10'd0, 10'd254, 28'h8000000);
        run_op("ovf_rne", 32'h7F800000, F_OVF | F_INE | F_INF);
        drive(2'b01, 1'b0, 5'd0, 10'd0, 10'd254, 28'h8000000);
        run_op("ovf_rtz", 32'h7F7FFFFF, F_OVF | F_INE);
        drive(2'b00, 1'b0, 5'd3, 10'd100, 10'd0, 28'h0800000);
        run_op("shift_left", 32'h32000000, 8'h00);
        drive(2'b00, 1'b0, 5'd0, 10'd1, 10'd0, 28'h000000C);
        run_op("denorm_unf", 32'h00000002, F_INE | F_UNF);
        drive(2'b00, 1'b0, 5'd0, 10'd1, 10'd0, 28'h3FFFFFC);
        run_op("denorm_to_norm", 32'h00800000, F_INE);
        drive(2'b00, 1'b0, 5'd0, 10'd127, 10'd127, 28'h7FFFFFC);
        run_op("mant_carry", 32'h40000000, F_INE);
        drive(2'b10, 1'b0, 5'd0, 10'd127, 10'd127, 28'h4000002);
        run_op("plusinf_pos", 32'h3F800001, F_INE);
        drive(2'b10, 1'b1, 5'd0, 10'd127, 10'd127, 28'h4000002);
        run_op("plusinf_neg", 32'hBF800000, F_INE);

        drive(2'b11, 1'b0, 5'd0, 10'd0, 10'd0, 28'h0);
        add_sub_0_i = 1'b1;
        run_op("sub0_minf", 32'h80000000, F_ZER);
        drive(2'b00, 1'b0, 5'd0, 10'd0, 10'd0, 28'h0);
        add_sub_0_i = 1'b1;
        run_op("sub0_rne", 32'h00000000, F_ZER);
        drive(2'b00, 1'b0, 5'd0, 10'd127, 10'd127, 28'h400000C);
        add_snan_i = 1'b1;
        add_anan_sign_i = 1'b1;
        run_op("snan", 32'hFFC00000, F_IVF | F_SNAN);
        drive(2'b00, 1'b0, 5'd0, 10'd127, 10'd127, 28'h400000C);
        add_inv_i = 1'b1;
        run_op("inv", 32'h7FC00000, F_IVF | F_QNAN);
        drive(2'b00, 1'b1, 5'd0, 10'd0, 10'd254, 28'h8000000);
        add_inf_i = 1'b1;
        run_op("inf", 32'hFF800000, F_INF);

        // Back-to-back with a stall between advances
        drive(2'b00, 1'b0, 5'd0, 10'd0, 10'd127, 28'h8000000);
        tick(1'b1);
        drive(2'b00, 1'b0, 5'd0, 10'd127, 10'd127, 28'h400000C);
        tick(1'b0);
        check_rdy("b2b_stall", 1'b0);
        tick(1'b1);
        check("b2b_first", 32'h40000000, 8'h00, 1'b1);
        add_rdy_i = 1'b0;
        tick(1'b0);
        check("b2b_hold", 32'h40000000, 8'h00, 1'b1);
        tick(1'b1);
        check("b2b_second", 32'h3F800002, F_INE, 1'b1);
        tick(1'b1);
        check_rdy("b2b_drain", 1'b0);

        // Flush on the second cycle: neither in-flight op may surface
        drive(2'b00, 1'b0, 5'd0, 10'd0, 10'd127, 28'h8000000);
        tick(1'b1);
        drive(2'b00, 1'b0, 5'd0, 10'd127, 10'd127, 28'h400000C);
        flush_i = 1'b1;
        tick(1'b1);
        flush_i = 1'b0;
        check_rdy("flush_now", 1'b0);
        add_rdy_i = 1'b0;
        tick(1'b1);
        check_rdy("flush_after1", 1'b0);
        tick(1'b1);
        check_rdy("flush_after2", 1'b0);
        drive(2'b00, 1'b0, 5'd3, 10'd100, 10'd0, 28'h0800000);
        run_op("post_flush", 32'h32000000, 8'h00);

        // Reset while an op sits in stage 1
        drive(2'b00, 1'b0, 5'd0, 10'd0, 10'd127, 28'h8000000);
        tick(1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_reset", 32'h0, 8'h00, 1'b0);
        #1;
        rst_n = 1'b1;
        add_rdy_i = 1'b0;
        tick(1'b1);
        check_rdy("post_reset1", 1'b0);
        tick(1'b1);
        check_rdy("post_reset2", 1'b0);
        drive(2'b01, 1'b0, 5'd0, 10'd127, 10'd127, 28'h400000C);
        run_op("post_reset_op", 32'h3F800001, F_INE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
